// File: rtl/addr_gen.sv
// addr_gen: 16-bit address generator for the adu address port.
// Assembles a staged address byte-wise from d, then jumps, increments,
// branches relatively and, when ADDR_GEN_STACK_EN is defined, calls and
// returns through a STACK_DEPTH-entry return-address LIFO.
// Build option: `define ADDR_GEN_STACK_EN to build the call/return stack;
// without it, call and ret are ignored entirely.
module addr_gen #(
    parameter logic [15:0] RESET_ADDR  = 16'h0000,
    parameter int          STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  d,
    input  logic        ll,
    input  logic        lh,
    input  logic        jmp,
    input  logic        inc,
    input  logic        rel,
    input  logic        call,
    input  logic        ret,
    output logic [15:0] a,
    output logic        we,
    output logic        err
);

    // Bit 0 = low byte valid, bit 1 = high byte valid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        LO    = 2'b01,
        HI    = 2'b10,
        FULL  = 2'b11
    } stage_t;

    stage_t      state;
    stage_t      state_nxt;
    logic [15:0] stg;
    logic [15:0] a_nxt;
    logic [15:0] a_inc;
    logic        exec;
    logic        err_set;
    logic        consume;
    logic [1:0]  base;

    // Relative branch offset: the data byte is a two's-complement displacement.
    function automatic logic signed [15:0] sext8(input logic signed [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    assign a_inc = a + 16'd1;

`ifdef ADDR_GEN_STACK_EN
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [15:0]      stack [STACK_DEPTH];
    logic [SP_W-1:0]  sp;
    logic             push;
    logic             pop;
    logic             stk_full;
    logic             stk_empty;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign stk_full  = (sp == SP_W'(STACK_DEPTH));
    assign stk_empty = (sp == '0);
    assign wr_idx    = sp[IDX_W-1:0];
    assign rd_idx    = IDX_W'(sp - SP_W'(1));
`else
    // Stackless build: call/ret have no effect and STACK_DEPTH is irrelevant.
    localparam int unused_depth = STACK_DEPTH;
    logic          unused_cmd;
    assign unused_cmd = call | ret;
`endif

    // Prioritised command decode: ret > call > jmp > rel > inc.
    always_comb begin
        exec    = 1'b0;
        err_set = 1'b0;
        consume = 1'b0;
        a_nxt   = a;
`ifdef ADDR_GEN_STACK_EN
        push    = 1'b0;
        pop     = 1'b0;
        if (ret) begin
            if (!stk_empty) begin
                exec  = 1'b1;
                pop   = 1'b1;
                a_nxt = stack[rd_idx];
            end else begin
                err_set = 1'b1;
            end
        end else if (call) begin
            if (state != FULL || stk_full) begin
                err_set = 1'b1;
            end else begin
                exec    = 1'b1;
                push    = 1'b1;
                consume = 1'b1;
                a_nxt   = stg;
            end
        end else
`endif
        if (jmp) begin
            if (state == FULL) begin
                exec    = 1'b1;
                consume = 1'b1;
                a_nxt   = stg;
            end else begin
                err_set = 1'b1;
            end
        end else if (rel) begin
            exec  = 1'b1;
            a_nxt = 16'($signed(a) + sext8($signed(d)));
        end else if (inc) begin
            exec  = 1'b1;
            a_nxt = a_inc;
        end
    end

    // Stage tracking: a consumed stage restarts from EMPTY before this
    // cycle's staged bytes are applied; reloading a valid byte keeps its state.
    always_comb begin
        base      = consume ? EMPTY : state;
        state_nxt = stage_t'({base[1] | lh, base[0] | ll});
    end

    // Registered address, strobe, sticky error, stage and stack pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            a     <= RESET_ADDR;
            we    <= 1'b0;
            err   <= 1'b0;
            stg   <= 16'h0000;
            state <= EMPTY;
`ifdef ADDR_GEN_STACK_EN
            sp    <= '0;
`endif
        end else begin
            a     <= a_nxt;
            we    <= exec;
            err   <= err | err_set;
            state <= state_nxt;
            if (ll) stg[7:0]  <= d;
            if (lh) stg[15:8] <= d;
`ifdef ADDR_GEN_STACK_EN
            if (push)     sp <= sp + SP_W'(1);
            else if (pop) sp <= sp - SP_W'(1);
`endif
        end
    end

`ifdef ADDR_GEN_STACK_EN
    // Return-address storage; contents are only meaningful below sp.
    always_ff @(posedge clk) begin
        if (push && !rst) stack[wr_idx] <= a_inc;
    end
`endif

endmodule

// File: tb/tb_addr_gen.sv
// Self-checking bench for addr_gen: directed test-plan steps followed by
// random command traffic, all checked against a queue-based reference model.
module tb_addr_gen;

    localparam logic [15:0] RST_A = 16'h0000;
    localparam int          DEPTH = 4;
`ifdef ADDR_GEN_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    localparam logic [6:0] C_LL   = 7'b0000001;
    localparam logic [6:0] C_LH   = 7'b0000010;
    localparam logic [6:0] C_JMP  = 7'b0000100;
    localparam logic [6:0] C_INC  = 7'b0001000;
    localparam logic [6:0] C_REL  = 7'b0010000;
    localparam logic [6:0] C_CALL = 7'b0100000;
    localparam logic [6:0] C_RET  = 7'b1000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  d = 8'h00;
    logic        ll = 1'b0, lh = 1'b0, jmp = 1'b0, inc = 1'b0;
    logic        rel = 1'b0, call = 1'b0, ret = 1'b0;
    logic [15:0] a;
    logic        we;
    logic        err;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [15:0] m_a   = RST_A;
    logic        m_we  = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] m_stg = 16'h0000;
    bit          m_lo  = 1'b0;
    bit          m_hi  = 1'b0;
    logic [15:0] m_stk[$];

    addr_gen #(.RESET_ADDR(RST_A), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .d(d), .ll(ll), .lh(lh), .jmp(jmp),
        .inc(inc), .rel(rel), .call(call), .ret(ret),
        .a(a), .we(we), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one clock edge, from pre-edge inputs and state.
    task automatic model(input logic r, input logic [7:0] dv, input logic [6:0] c);
        logic [15:0] na;
        bit          ex, used, full;
        int          sum;
        if (r) begin
            m_a = RST_A; m_we = 0; m_err = 0; m_stg = 16'h0000;
            m_lo = 0; m_hi = 0; m_stk.delete();
            return;
        end
        na = m_a; ex = 0; used = 0; full = m_lo && m_hi;
        if (STK && c[6]) begin
            if (m_stk.size() > 0) begin na = m_stk.pop_back(); ex = 1; end
            else m_err = 1;
        end else if (STK && c[5]) begin
            if (!full || m_stk.size() == DEPTH) m_err = 1;
            else begin m_stk.push_back(m_a + 16'd1); na = m_stg; ex = 1; used = 1; end
        end else if (c[2]) begin
            if (full) begin na = m_stg; ex = 1; used = 1; end
            else m_err = 1;
        end else if (c[4]) begin
            sum = int'(m_a) + int'($signed(dv));
            na = sum[15:0]; ex = 1;
        end else if (c[3]) begin
            na = m_a + 16'd1; ex = 1;
        end
        if (used) begin m_lo = 0; m_hi = 0; end
        if (c[0]) begin m_stg[7:0]  = dv; m_lo = 1; end
        if (c[1]) begin m_stg[15:8] = dv; m_hi = 1; end
        m_a = na; m_we = ex;
    endtask

    // Drive one cycle of inputs, clock it, and compare DUT to the model.
    task automatic step(input logic r, input logic [7:0] dv, input logic [6:0] c);
        rst = r; d = dv;
        {ret, call, rel, inc, jmp, lh, ll} = c;
        @(posedge clk);
        model(r, dv, c);
        #1;
        chk("a", a, m_a);
        chk("we", 16'(we), 16'(m_we));
        chk("err", 16'(err), 16'(m_err));
    endtask

    task automatic load(input logic [15:0] v);
        step(0, v[7:0], C_LL);
        step(0, v[15:8], C_LH);
    endtask

    initial begin
        logic [6:0] c;
        logic       r;
        #1;
        // Reset and idle.
        step(1, 8'h00, 7'b0);
        step(1, 8'h00, 7'b0);
        repeat (3) step(0, 8'h00, 7'b0);
        chk("idle_a", a, 16'h0000);
        chk("idle_we", 16'(we), 16'h0000);
        chk("idle_err", 16'(err), 16'h0000);

        // Byte staging and jump; second jump without a stage is an error.
        step(0, 8'h34, C_LL);
        step(0, 8'h12, C_LH);
        step(0, 8'h00, C_JMP);
        chk("jmp_a", a, 16'h1234);
        chk("jmp_we", 16'(we), 16'h0001);
        step(0, 8'h00, C_JMP);
        chk("jmp2_a", a, 16'h1234);
        chk("jmp2_err", 16'(err), 16'h0001);
        chk("jmp2_we", 16'(we), 16'h0000);

        // Wrap on increment, then relative branch back by two.
        step(1, 8'h00, 7'b0);
        load(16'hFFFE);
        step(0, 8'h00, C_JMP);
        step(0, 8'h00, C_INC);
        chk("inc1", a, 16'hFFFF);
        step(0, 8'h00, C_INC);
        chk("inc2", a, 16'h0000);
        step(0, 8'h00, C_INC);
        chk("inc3", a, 16'h0001);
        chk("inc3_we", 16'(we), 16'h0001);
        step(0, 8'hFE, C_REL);
        chk("rel_neg", a, 16'hFFFF);
        step(0, 8'h80, C_REL);
        chk("rel_80", a, 16'hFF7F);
        step(0, 8'h00, C_REL);
        chk("rel_zero_we", 16'(we), 16'h0001);

        // Priority: jmp beats rel and inc.
        load(16'hABCD);
        step(0, 8'h10, C_INC | C_REL | C_JMP);
        chk("prio_a", a, 16'hABCD);
        step(0, 8'h00, 7'b0);
        chk("prio_we_drop", 16'(we), 16'h0000);

        // Same-cycle ll+lh loads both bytes; jmp then uses the old stage.
        step(0, 8'h5A, C_LL | C_LH);
        load(16'h1111);
        step(0, 8'h77, C_JMP | C_LL | C_LH);
        chk("stage_jmp", a, 16'h1111);
        step(0, 8'h00, C_JMP);
        chk("stage_restage", a, 16'h7777);

`ifdef ADDR_GEN_STACK_EN
        // Fill the stack, overflow, drain, underflow.
        step(1, 8'h00, 7'b0);
        load(16'h0100);
        step(0, 8'h00, C_JMP);
        repeat (4) begin
            load(16'h2000);
            step(0, 8'h00, C_CALL);
            chk("call_a", a, 16'h2000);
        end
        load(16'h3000);
        step(0, 8'h00, C_CALL);
        chk("call_ovf_a", a, 16'h2000);
        chk("call_ovf_err", 16'(err), 16'h0001);
        step(0, 8'h00, C_RET);
        chk("ret1", a, 16'h2001);
        step(0, 8'h00, C_RET);
        step(0, 8'h00, C_RET);
        chk("ret3", a, 16'h2001);
        step(0, 8'h00, C_RET);
        chk("ret4", a, 16'h0101);
        step(0, 8'h00, C_RET);
        chk("ret_unf_we", 16'(we), 16'h0000);
`else
        // Stackless build: call/ret are transparent to lower priorities.
        step(1, 8'h00, 7'b0);
        load(16'h4000);
        step(0, 8'h00, C_CALL | C_RET | C_INC);
        chk("nostk_inc", a, 16'h0001);
        chk("nostk_err", 16'(err), 16'h0000);
`endif

        // Reset overrides a jump and aborts the stage.
        load(16'h9999);
        step(1, 8'h00, C_JMP);
        chk("rst_jmp_a", a, RST_A);
        chk("rst_jmp_we", 16'(we), 16'h0000);
        step(0, 8'h00, C_JMP);
        chk("rst_stage_err", 16'(err), 16'h0001);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 39) == 0);
            c[0] = ($urandom_range(0, 2) == 0);
            c[1] = ($urandom_range(0, 2) == 0);
            c[2] = ($urandom_range(0, 4) == 0);
            c[3] = ($urandom_range(0, 2) == 0);
            c[4] = ($urandom_range(0, 3) == 0);
            c[5] = ($urandom_range(0, 6) == 0);
            c[6] = ($urandom_range(0, 6) == 0);
            step(r, 8'($urandom), c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
